// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-addressed synchronous-write data memory.
// Handles alignment/range faults, load extension, and read-modify-write for SB/SH.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [AW-1:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_MERGE  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]    state_q, state_d;
  logic          is_store_q, is_store_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;
  logic          resp_fault_q, resp_fault_d;

  logic          fault_c;
  logic [7:0]    lane_byte_c;
  logic [15:0]   lane_half_c;
  logic [DW-1:0] load_val_c;
  logic [DW-1:0] merged_c;

  // Fault classification from the latched request
  always_comb begin
    fault_c = 1'b0;
    case (funct3_q)
      F3_B:    fault_c = 1'b0;
      F3_H:    fault_c = addr_q[0];
      F3_W:    fault_c = |addr_q[1:0];
      F3_BU:   fault_c = is_store_q;
      F3_HU:   fault_c = is_store_q | addr_q[0];
      default: fault_c = 1'b1;
    endcase
    if (addr_q >= ADDR_LIMIT) fault_c = 1'b1;
  end

  // Lane extraction for loads and lane replacement for sub-word stores
  always_comb begin
    lane_byte_c = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
    lane_half_c = mem_read_data[{addr_q[1], 4'b0000} +: 16];
    load_val_c  = mem_read_data;
    case (funct3_q)
      F3_B:    load_val_c = {{24{lane_byte_c[7]}}, lane_byte_c};
      F3_H:    load_val_c = {{16{lane_half_c[15]}}, lane_half_c};
      F3_BU:   load_val_c = {24'h000000, lane_byte_c};
      F3_HU:   load_val_c = {16'h0000, lane_half_c};
      default: load_val_c = mem_read_data;
    endcase
    merged_c = mem_read_data;
    if (funct3_q == F3_H) merged_c[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else                  merged_c[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  // Next-state and register updates
  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          is_store_d = req_is_store;
          funct3_d   = req_funct3;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (fault_c) begin
          resp_fault_d = 1'b1;
          resp_rdata_d = '0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (!is_store_q) begin
          resp_fault_d = 1'b0;
          resp_rdata_d = load_val_c;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (funct3_q == F3_W) begin
          resp_fault_d = 1'b0;
          resp_rdata_d = '0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          wdata_d = merged_c;
          state_d = S_MERGE;
        end
      end
      S_MERGE: begin
        resp_fault_d = 1'b0;
        resp_rdata_d = '0;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  // Strobe only for a non-faulting SW in ACCESS or the RMW write-back in MERGE
  assign mem_write_enable = ((state_q == S_ACCESS) && is_store_q && !fault_c && (funct3_q == F3_W))
                          || (state_q == S_MERGE);
  assign req_ready      = (state_q == S_IDLE);
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_fault     = resp_fault_q;
  assign mem_address    = {addr_q[AW-1:2], 2'b00};
  assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:255];
  logic        load_mem = 1'b1;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_is_store     (req_is_store),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_fault       (resp_fault),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[0] <= 32'hDEADBEEF;
      mem[1] <= 32'h12345678;
    end else if (mem_write_enable) begin
      mem[mem_address[9:2]] <= mem_write_data;
    end
  end

  assign mem_read_data = mem[mem_address[9:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request; reports response latency, strobe count and cycle of the last strobe.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output int strobes,
                        output int scyc, output logic [31:0] rd, output logic flt);
    int c;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    strobes = 0; scyc = 0; rd = 32'hX; flt = 1'bX;
    for (c = 1; c <= 10; c++) begin
      if (mem_write_enable) begin strobes++; scyc = c; end
      if (resp_valid) break;
      @(posedge clk); #1;
    end
    lat = c;
    rd = resp_rdata;
    flt = resp_fault;
    if (resp_ready && resp_valid) begin
      @(posedge clk); #1;
    end
  endtask

  int lat, strobes, scyc;
  logic [31:0] rd;
  logic flt;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_fault", 32'(resp_fault), 32'h0);
    chk("rst_wen", 32'(mem_write_enable), 32'h0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    load_mem = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Loads from mem[0]=DEADBEEF
    do_req(1'b0, 3'b000, 32'h3, 32'h0, lat, strobes, scyc, rd, flt);
    chk("lb3_rdata", rd, 32'hFFFFFFDE); chk("lb3_lat", 32'(lat), 32'd2);
    chk("lb3_fault", 32'(flt), 32'h0); chk("lb3_strobes", 32'(strobes), 32'd0);
    do_req(1'b0, 3'b100, 32'h1, 32'h0, lat, strobes, scyc, rd, flt);
    chk("lbu1_rdata", rd, 32'h000000BE); chk("lbu1_lat", 32'(lat), 32'd2);
    chk("lbu1_fault", 32'(flt), 32'h0); chk("lbu1_strobes", 32'(strobes), 32'd0);
    do_req(1'b0, 3'b001, 32'h2, 32'h0, lat, strobes, scyc, rd, flt);
    chk("lh2_rdata", rd, 32'hFFFFDEAD); chk("lh2_lat", 32'(lat), 32'd2);
    chk("lh2_fault", 32'(flt), 32'h0); chk("lh2_strobes", 32'(strobes), 32'd0);
    do_req(1'b0, 3'b101, 32'h0, 32'h0, lat, strobes, scyc, rd, flt);
    chk("lhu0_rdata", rd, 32'h0000BEEF); chk("lhu0_lat", 32'(lat), 32'd2);
    chk("lhu0_fault", 32'(flt), 32'h0); chk("lhu0_strobes", 32'(strobes), 32'd0);

    // Sub-word stores into mem[1]=12345678
    do_req(1'b1, 3'b000, 32'h5, 32'hAAAAAA55, lat, strobes, scyc, rd, flt);
    chk("sb5_mem", mem[1], 32'h12345578); chk("sb5_lat", 32'(lat), 32'd3);
    chk("sb5_strobes", 32'(strobes), 32'd1); chk("sb5_strobe_cyc", 32'(scyc), 32'd2);
    chk("sb5_fault", 32'(flt), 32'h0); chk("sb5_rdata", rd, 32'h0);
    do_req(1'b1, 3'b001, 32'h6, 32'h0000BEEF, lat, strobes, scyc, rd, flt);
    chk("sh6_mem", mem[1], 32'hBEEF5578); chk("sh6_lat", 32'(lat), 32'd3);
    chk("sh6_strobes", 32'(strobes), 32'd1); chk("sh6_strobe_cyc", 32'(scyc), 32'd2);

    // Full-word store then load back
    do_req(1'b1, 3'b010, 32'h78, 32'hCAFEF00D, lat, strobes, scyc, rd, flt);
    chk("sw78_mem", mem[30], 32'hCAFEF00D); chk("sw78_lat", 32'(lat), 32'd2);
    chk("sw78_strobes", 32'(strobes), 32'd1); chk("sw78_strobe_cyc", 32'(scyc), 32'd1);
    do_req(1'b0, 3'b010, 32'h78, 32'h0, lat, strobes, scyc, rd, flt);
    chk("lw78_rdata", rd, 32'hCAFEF00D); chk("lw78_fault", 32'(flt), 32'h0);

    // Faults
    do_req(1'b0, 3'b010, 32'h2, 32'h0, lat, strobes, scyc, rd, flt);
    chk("f_lw2_fault", 32'(flt), 32'h1); chk("f_lw2_rdata", rd, 32'h0);
    chk("f_lw2_strobes", 32'(strobes), 32'd0); chk("f_lw2_lat", 32'(lat), 32'd2);
    do_req(1'b1, 3'b001, 32'h81, 32'h1234, lat, strobes, scyc, rd, flt);
    chk("f_sh81_fault", 32'(flt), 32'h1); chk("f_sh81_rdata", rd, 32'h0);
    chk("f_sh81_strobes", 32'(strobes), 32'd0); chk("f_sh81_mem", mem[32], 32'h0);
    do_req(1'b0, 3'b010, 32'h400, 32'h0, lat, strobes, scyc, rd, flt);
    chk("f_lw400_fault", 32'(flt), 32'h1); chk("f_lw400_rdata", rd, 32'h0);
    chk("f_lw400_strobes", 32'(strobes), 32'd0);
    do_req(1'b1, 3'b100, 32'h0, 32'h11, lat, strobes, scyc, rd, flt);
    chk("f_sbu_fault", 32'(flt), 32'h1); chk("f_sbu_rdata", rd, 32'h0);
    chk("f_sbu_strobes", 32'(strobes), 32'd0); chk("f_sbu_mem", mem[0], 32'hDEADBEEF);

    // Backpressure: response held, competing request not accepted
    resp_ready = 1'b0;
    do_req(1'b0, 3'b100, 32'h0, 32'h0, lat, strobes, scyc, rd, flt);
    chk("bp_rdata", rd, 32'h000000EF); chk("bp_lat", 32'(lat), 32'd2);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h78; req_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(resp_valid), 32'h1);
      chk("bp_hold_rdata", resp_rdata, 32'h000000EF);
      chk("bp_hold_fault", 32'(resp_fault), 32'h0);
      chk("bp_hold_ready", 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", 32'(req_ready), 32'h1);
    chk("bp_idle_valid", 32'(resp_valid), 32'h0);
    do_req(1'b0, 3'b010, 32'h78, 32'h0, lat, strobes, scyc, rd, flt);
    chk("bp_next_rdata", rd, 32'hCAFEF00D); chk("bp_next_lat", 32'(lat), 32'd2);

    // Reset during MERGE of an SB to mem[0]
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_wen_merge", 32'(mem_write_enable), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wen", 32'(mem_write_enable), 32'h0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'h1);
    chk("rst_mid_resp_valid", 32'(resp_valid), 32'h0);
    @(posedge clk); #1;
    chk("rst_mid_mem", mem[0], 32'hDEADBEEF);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 3'b010, 32'h0, 32'h0, lat, strobes, scyc, rd, flt);
    chk("post_rst_rdata", rd, 32'hDEADBEEF); chk("post_rst_lat", 32'(lat), 32'd2);
    chk("post_rst_fault", 32'(flt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
